// File: rtl/golay_pkg.sv
// Shared constants for the extended Golay(24,12,8) code: the parity matrix B
// (symmetric, self-inverse) and the sequential decoder state encoding.
package golay_pkg;

  // Row i is b_i; bit j of a row is column j of B (bit 0 = column 0).
  localparam logic [11:0][11:0] GOLAY_B = {
    12'b011111111111,  // row 11
    12'b110001110110,  // row 10
    12'b100011101101,  // row 9
    12'b100111011010,  // row 8
    12'b101110110100,  // row 7
    12'b111101101000,  // row 6
    12'b111011010001,  // row 5
    12'b110110100011,  // row 4
    12'b101101000111,  // row 3
    12'b111010001110,  // row 2
    12'b110100011101,  // row 1
    12'b101000111011   // row 0
  };

  typedef enum logic [2:0] {
    IDLE,
    SYND,
    SCAN1,
    QCALC,
    SCAN2
  } state_t;

  // Row vector times B over GF(2).
  function automatic logic [11:0] mul_b(input logic [11:0] v);
    logic [11:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (v[4'(i)]) acc = acc ^ GOLAY_B[4'(i)];
    end
    return acc;
  endfunction

endpackage

// File: rtl/golay_weight12.sv
// Combinational 12-bit population count.
module golay_weight12 (
  input  logic [11:0] vec,
  output logic [3:0]  wt
);

  always_comb begin
    wt = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      wt = wt + {3'b000, vec[4'(i)]};
    end
  end

endmodule

// File: rtl/golay_seq_decoder.sv
// Sequential extended Golay(24,12,8) decoder: syndrome, then one B row per
// cycle against s, then against q = s*B; corrects up to 3 bit errors.
module golay_seq_decoder
  import golay_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stb_dec,
  input  logic [23:0] codepay,
  output logic        busy,
  output logic        decoded,
  output logic        failed,
  output logic [11:0] payload_rec
);

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [11:0] r1, r1_nxt, r2, r2_nxt;
  logic [11:0] s, s_nxt, q, q_nxt;
  logic [11:0] pay_nxt;
  logic        dec_nxt, fail_nxt;

  logic [11:0] base_vec, row_vec;
  logic [3:0]  base_wt, row_wt;

  // One weight unit serves s in SCAN1 and q in SCAN2.
  assign base_vec = (state == SCAN2) ? q : s;
  assign row_vec  = base_vec ^ GOLAY_B[idx];

  golay_weight12 u_wt_base (
    .vec (base_vec),
    .wt  (base_wt)
  );

  golay_weight12 u_wt_row (
    .vec (row_vec),
    .wt  (row_wt)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    r1_nxt    = r1;
    r2_nxt    = r2;
    s_nxt     = s;
    q_nxt     = q;
    pay_nxt   = payload_rec;
    dec_nxt   = 1'b0;
    fail_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (stb_dec) begin
          r1_nxt    = codepay[23:12];
          r2_nxt    = codepay[11:0];
          state_nxt = SYND;
        end
      end
      SYND: begin
        s_nxt     = mul_b(r1) ^ r2;
        idx_nxt   = '0;
        state_nxt = SCAN1;
      end
      SCAN1: begin
        if ((idx == 4'd0) && (base_wt <= 4'd3)) begin
          pay_nxt   = r1;
          dec_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (row_wt <= 4'd2) begin
          pay_nxt   = r1 ^ (12'd1 << idx);
          dec_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (idx == 4'd11) begin
          state_nxt = QCALC;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      QCALC: begin
        q_nxt     = mul_b(s);
        idx_nxt   = '0;
        state_nxt = SCAN2;
      end
      SCAN2: begin
        if ((idx == 4'd0) && (base_wt <= 4'd3)) begin
          pay_nxt   = r1 ^ q;
          dec_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (row_wt <= 4'd2) begin
          pay_nxt   = r1 ^ q ^ GOLAY_B[idx];
          dec_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (idx == 4'd11) begin
          pay_nxt   = r1;
          fail_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      r1          <= '0;
      r2          <= '0;
      s           <= '0;
      q           <= '0;
      payload_rec <= '0;
      decoded     <= 1'b0;
      failed      <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      r1          <= r1_nxt;
      r2          <= r2_nxt;
      s           <= s_nxt;
      q           <= q_nxt;
      payload_rec <= pay_nxt;
      decoded     <= dec_nxt;
      failed      <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_golay_seq_decoder.sv
// Randomized self-checking bench for golay_seq_decoder with a word-level
// reference model and per-cycle output comparison.
module tb_golay_seq_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stb_dec = 1'b0;
  logic [23:0] codepay = '0;
  logic        busy, decoded, failed;
  logic [11:0] payload_rec;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  golay_seq_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .stb_dec     (stb_dec),
    .codepay     (codepay),
    .busy        (busy),
    .decoded     (decoded),
    .failed      (failed),
    .payload_rec (payload_rec)
  );

  // B written as in textbooks: leftmost character is column 0.
  logic [11:0] b_txt [12] = '{
    12'b110111000101, 12'b101110001011, 12'b011100010111, 12'b111000101101,
    12'b110001011011, 12'b100010110111, 12'b000101101111, 12'b001011011101,
    12'b010110111001, 12'b101101110001, 12'b011011100011, 12'b111111111110
  };

  typedef struct packed {
    logic       ok;
    logic [5:0] lat;
    logic [11:0] pay;
  } res_t;

  function automatic logic [11:0] brow(input int i);
    logic [11:0] t, r;
    t = b_txt[i];
    for (int j = 0; j < 12; j++) r[j] = t[11 - j];
    return r;
  endfunction

  function automatic logic [11:0] times_b(input logic [11:0] v);
    logic [11:0] acc = '0;
    for (int i = 0; i < 12; i++) if (v[i]) acc ^= brow(i);
    return acc;
  endfunction

  function automatic res_t model_decode(input logic [23:0] w);
    logic [11:0] r1, s, q;
    r1 = w[23:12];
    s  = times_b(r1) ^ w[11:0];
    for (int i = 0; i < 12; i++) begin
      if (i == 0 && $countones(s) <= 3) return '{1'b1, 6'd2, r1};
      if ($countones(s ^ brow(i)) <= 2) return '{1'b1, 6'(2 + i), r1 ^ (12'd1 << i)};
    end
    q = times_b(s);
    for (int i = 0; i < 12; i++) begin
      if (i == 0 && $countones(q) <= 3) return '{1'b1, 6'd15, r1 ^ q};
      if ($countones(q ^ brow(i)) <= 2) return '{1'b1, 6'(15 + i), r1 ^ q ^ brow(i)};
    end
    return '{1'b0, 6'd26, r1};
  endfunction

  // Cycle-level expectation derived from the word-level model.
  logic        m_active = 1'b0;
  logic        m_dec = 1'b0, m_fail = 1'b0;
  logic [11:0] m_pay = '0;
  int          m_cnt = 0;
  res_t        m_res = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_dec    <= 1'b0;
      m_fail   <= 1'b0;
      m_pay    <= '0;
    end else begin
      m_dec  <= 1'b0;
      m_fail <= 1'b0;
      if (m_active) begin
        if (m_cnt + 1 == int'(m_res.lat)) begin
          m_dec    <= m_res.ok;
          m_fail   <= !m_res.ok;
          m_pay    <= m_res.pay;
          m_active <= 1'b0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (stb_dec) begin
        m_res    <= model_decode(codepay);
        m_cnt    <= 0;
        m_active <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if ({busy, decoded, failed, payload_rec} !== {m_active, m_dec, m_fail, m_pay}) begin
      n_bad++;
      $display("FAIL cycle_outputs t=%0t: busy/dec/fail/pay got %b%b%b/%03h expected %b%b%b/%03h",
               $time, busy, decoded, failed, payload_rec, m_active, m_dec, m_fail, m_pay);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send one word, wait (bounded) for its pulse, optionally poking stb while busy.
  task automatic send_word(input logic [23:0] w, input bit noise,
                           output int lat, output bit ok, output logic [11:0] pay);
    bit got;
    @(negedge clk);
    stb_dec = 1'b1;
    codepay = w;
    @(posedge clk);
    #1;
    stb_dec = 1'b0;
    codepay = 24'($urandom);
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      stb_dec = 1'b0;
      if (decoded || failed) begin
        got = 1'b1;
      end else if (noise && (lat == 3 || $urandom_range(0, 3) == 0)) begin
        stb_dec = 1'b1;
        codepay = 24'($urandom);
      end
    end
    stb_dec = 1'b0;
    ok  = decoded;
    pay = payload_rec;
    if (!got) check("pulse_timeout", 32'(lat), 32'd0);
  endtask

  task automatic directed(input string name, input logic [23:0] w, input bit noise,
                          input int exp_lat, input bit exp_ok, input logic [11:0] exp_pay);
    int lat;
    bit ok;
    logic [11:0] pay;
    send_word(w, noise, lat, ok, pay);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_status"}, {30'd0, decoded, failed}, {30'd0, exp_ok, !exp_ok});
    check({name, "_payload"}, 32'(pay), 32'(exp_pay));
  endtask

  initial begin
    int lat;
    bit ok;
    logic [11:0] pay, data, par;
    logic [23:0] err, w;
    int nerr;
    res_t r;

    // Pin the model with hand-derived values.
    check("model_zero", 32'(model_decode(24'h000000)), 32'({1'b1, 6'd2, 12'h000}));
    check("model_p3", 32'(model_decode(24'h000007)), 32'({1'b1, 6'd2, 12'h000}));
    check("model_row1", 32'(model_decode(24'h002000)), 32'({1'b1, 6'd3, 12'h000}));
    check("model_d3", 32'(model_decode(24'h007000)), 32'({1'b1, 6'd15, 12'h000}));
    check("model_d4", 32'(model_decode(24'h00F000)), 32'({1'b0, 6'd26, 12'h00F}));
    check("model_b_inverse", 32'(times_b(times_b(12'hA5C))), 32'h0A5C);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {19'd0, busy, decoded, failed, payload_rec}, 32'd0);
    reset = 1'b0;

    directed("zero", 24'h000000, 1'b0, 2, 1'b1, 12'h000);
    directed("par3", 24'h000007, 1'b0, 2, 1'b1, 12'h000);
    directed("pay_bit0", 24'h001000, 1'b0, 2, 1'b1, 12'h000);
    directed("pay_bit1", 24'h002000, 1'b0, 3, 1'b1, 12'h000);
    directed("pay3", 24'h007000, 1'b0, 15, 1'b1, 12'h000);
    directed("four_err", 24'h00F000, 1'b1, 26, 1'b0, 12'h00F);

    // Abort mid-decode with reset.
    @(negedge clk);
    stb_dec = 1'b1;
    codepay = 24'h00F000;
    @(negedge clk);
    stb_dec = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_outputs", {19'd0, busy, decoded, failed, payload_rec}, 32'd0);
    directed("after_abort", 24'h001000, 1'b0, 2, 1'b1, 12'h000);

    // Strobe coincident with reset is dropped.
    @(negedge clk);
    reset = 1'b1;
    stb_dec = 1'b1;
    codepay = 24'h007000;
    @(negedge clk);
    reset = 1'b0;
    stb_dec = 1'b0;
    check("stb_during_reset", {31'd0, busy}, 32'd0);
    directed("after_drop", 24'h004000, 1'b0, 4, 1'b1, 12'h000);

    for (int k = 0; k < 80; k++) begin
      data = 12'($urandom);
      par  = times_b(data);
      nerr = $urandom_range(0, 4);
      err  = '0;
      while ($countones(err) < nerr) err[$urandom_range(0, 23)] = 1'b1;
      w = {data, par} ^ err;
      r = model_decode(w);
      send_word(w, k[0], lat, ok, pay);
      check("rand_latency", 32'(lat), 32'(r.lat));
      check("rand_status", {31'd0, ok}, {31'd0, r.ok});
      check("rand_payload", 32'(pay), 32'(r.pay));
      if (nerr <= 3) check("rand_corrects", {19'd0, ok, pay}, {19'd0, 1'b1, data});
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/golay_seq_decoder.md
GOLAY_SEQ_DECODER -- requirements
Module: golay_seq_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 The block SHALL have port stb_dec  input  1  single-cycle strobe; codepay is valid this cycle.
REQ-003 The block SHALL have port codepay  input  24  received word: [23:12] payload r1, [11:0] parity r2.
REQ-004 The block SHALL have port busy  output  1  high while a word is being decoded.
REQ-005 The block SHALL have port decoded  output  1  one-cycle pulse: correction succeeded.
REQ-006 The block SHALL have port failed  output  1  one-cycle pulse: uncorrectable word.
REQ-007 The block SHALL have port payload_rec  output  12  corrected payload, valid from the pulse edge, held until the next pulse.

Function
REQ-008 The block SHALL decode extended Golay(24,12,8), G=[I|B], correcting up to 3 bit errors; B is symmetric with B·B=I; row i of B (b_i) corresponds to payload bit i (bit 0 = row 0).
REQ-009 The FSM SHALL use states IDLE, SYND, SCAN1, QCALC, SCAN2 and SHALL advance one state or row per clk.
REQ-010 In IDLE, stb_dec=1 SHALL latch codepay and move to SYND; stb_dec while not IDLE SHALL be ignored with no side effect.
REQ-011 SYND SHALL register s = r1·B xor r2, clear row index i to 0, and move to SCAN1.
REQ-012 In SCAN1, when i=0 and wt(s)<=3, the block SHALL finish with payload_rec=r1; this check takes priority over the row check.
REQ-013 Otherwise, in SCAN1, wt(s xor b_i)<=2 SHALL finish with payload_rec = r1 xor onehot(i).
REQ-014 If SCAN1 has no hit, i SHALL increment; when i=11 has no hit, the FSM SHALL move to QCALC.
REQ-015 QCALC SHALL register q = s·B, clear i, and move to SCAN2.
REQ-016 In SCAN2, i=0 and wt(q)<=3 SHALL finish with payload_rec = r1 xor q.
REQ-017 Otherwise, in SCAN2, wt(q xor b_i)<=2 SHALL finish with payload_rec = r1 xor q xor b_i.
REQ-018 When SCAN2 has no hit at i=11, the block SHALL pulse failed and set payload_rec=r1 (uncorrected).
REQ-019 Finishing SHALL mean: the status pulse and payload_rec update on the same edge, and return to IDLE on that edge.
REQ-020 Latency SHALL be measured from the edge that samples stb_dec to the edge that raises the pulse.
REQ-021 Latency SHALL be 2+k for a SCAN1 hit at row k, 15+k for a SCAN2 hit at row k, and 26 for failed.
REQ-022 A new stb_dec SHALL be accepted on the cycle after the pulse; peak throughput is one word per 3 cycles.
REQ-023 decoded and failed SHALL never be high together, and each SHALL be high for exactly 1 cycle per accepted word.
REQ-024 busy SHALL be high from the edge after acceptance until the pulse edge inclusive of that cycle, and low in IDLE.
REQ-025 All weights SHALL be popcounts over 12 bits compared unsigned, and all arithmetic SHALL be GF(2) (xor/and).

Reset
REQ-026 reset SHALL force IDLE and clear i, s, q and the latched word.
REQ-027 reset SHALL set busy=0, decoded=0, failed=0 and payload_rec=12'h000.
REQ-028 reset asserted mid-decode SHALL abort the decode with no pulse; the first stb_dec sampled after reset deasserts SHALL be accepted.
REQ-029 stb_dec sampled in the same cycle as reset SHALL be dropped.

Structure
REQ-030 Package golay_pkg SHALL hold the constant GOLAY_B (12 rows x 12 bits, the same matrix the encoder uses) and the FSM state enum; the block SHALL not duplicate them locally.
REQ-031 The 12-bit popcount SHALL be one sub-module, golay_weight12 (combinational, 4-bit output), instanced for the s/q and xor-row checks.

Verification
REQ-032 The bench SHALL cover: codepay=24'h000000 -> decoded at latency 2, payload_rec=12'h000, failed never high.
REQ-033 The bench SHALL cover: codepay=24'h000007 (3 parity errors) -> decoded at latency 2, payload_rec=12'h000.
REQ-034 The bench SHALL cover: codepay=24'h001000 (payload bit 0 error) -> SCAN1 row 0 hit, decoded at latency 2, payload_rec=12'h000; codepay=24'h002000 -> latency 3.
REQ-035 The bench SHALL cover: codepay=24'h007000 (3 payload errors) -> decoded at latency 15, payload_rec=12'h000.
REQ-036 The bench SHALL cover: codepay=24'h00F000 (4 errors) -> failed at latency 26, payload_rec=12'h00F; a second stb_dec sent while busy=1 is ignored.
REQ-037 The bench SHALL cover: reset pulsed 5 cycles after accepting 24'h00F000 -> no pulse, busy=0, payload_rec=12'h000; the next word decodes normally.
